// File: rtl/demux_route_serializer_pkg.sv
// Shared definitions for the demux route serializer: FSM state encoding and
// demux channel indices.
package demux_route_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter with a terminal-count flag. The counter stops at zero,
// and the flag is high whenever the count is zero.
module down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/demux_route_serializer.sv
// Serializes a parallel word LSB-first onto the demux data line, holds the
// select for the whole frame, then inserts an idle gap.
module demux_route_serializer
  import demux_route_serializer_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_dest,
  input  logic [DATA_W-1:0] in_data,
  input  logic              abort,
  output logic              f,
  output logic [1:0]        sel,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned     BW       = $clog2(DATA_W + 1);
  localparam logic [BW-1:0]   BIT_LOAD = BW'(DATA_W - 1);
  localparam logic [3:0]      GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              bit_tc;
  logic              gap_tc;
  logic              gap_load;
  logic              done_nxt;
  logic [DATA_W-1:0] shreg;

  // Bit counter reads zero while the last payload bit is on f.
  down_counter #(.W(BW)) u_bit_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .en       (state == ST_SHIFT),
    .load_val (BIT_LOAD),
    .tc       (bit_tc)
  );

  down_counter #(.W(4)) u_gap_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .en       (state == ST_GAP),
    .load_val (GAP_LOAD),
    .tc       (gap_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (in_valid) state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (bit_tc) begin
          state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP:   if (abort || gap_tc) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_IDLE);
    busy     = (state != ST_IDLE);
    accept   = in_ready && in_valid;
    gap_load = (state == ST_SHIFT) && bit_tc;
    done_nxt = !abort &&
               (((state == ST_SHIFT) && bit_tc && (GAP_CYCLES == 0)) ||
                ((state == ST_GAP) && gap_tc));
  end

  // Bit 0 goes straight to f on accept; shreg holds only the bits still to send.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      f          <= 1'b0;
      sel        <= CH_A;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done_nxt;
      if (accept) begin
        shreg <= in_data >> 1;
        f     <= in_data[0];
        sel   <= in_dest;
      end else if ((state == ST_SHIFT) && !abort && !bit_tc) begin
        shreg <= shreg >> 1;
        f     <= shreg[0];
      end else begin
        f <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_demux_route_serializer.sv
// Randomized self-checking bench for demux_route_serializer, with a frame-level
// reference model and a second instance covering the one-bit, no-gap corner.
module tb_demux_route_serializer;
  import demux_route_serializer_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned G = 2;
  localparam int unsigned P = W + G + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0, abort = 1'b0;
  logic [1:0]   in_dest = 2'd0;
  logic [W-1:0] in_data = '0;
  logic         f, in_ready, busy, frame_done;
  logic [1:0]   sel;

  logic         in_valid1 = 1'b0, abort1 = 1'b0;
  logic [1:0]   in_dest1 = 2'd0;
  logic [0:0]   in_data1 = 1'b0;
  logic         f1, in_ready1, busy1, fd1;
  logic [1:0]   sel1;
  logic [3:0]   route;

  int checks = 0;
  int fails  = 0;

  demux_route_serializer #(.DATA_W(W), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_data(in_data), .abort(abort), .f(f), .sel(sel),
    .busy(busy), .frame_done(frame_done)
  );

  demux_route_serializer #(.DATA_W(1), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_dest(in_dest1), .in_data(in_data1), .abort(abort1), .f(f1), .sel(sel1),
    .busy(busy1), .frame_done(fd1)
  );

  // Downstream 1-to-4 demux: a=bit0 .. d=bit3.
  assign route = f1 ? (4'b0001 << sel1) : 4'b0000;

  // Expected {f, sel, busy, in_ready, frame_done} k cycles after an accept edge.
  function automatic logic [5:0] model(input logic [W-1:0] d, input logic [1:0] dst,
                                       input int unsigned k);
    if (k >= 1 && k <= W) return {d[k-1], dst, 1'b1, 1'b0, 1'b0};
    if (k >= 1 && k <= W + G) return {1'b0, dst, 1'b1, 1'b0, 1'b0};
    return {1'b0, dst, 1'b0, 1'b1, (k == P)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({f, sel, busy, in_ready, frame_done} !== 6'b0_00_010) begin
      fails++;
      $display("FAIL reset_hold: got %b expected %b", {f, sel, busy, in_ready, frame_done}, 6'b0_00_010);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({f, sel, busy, in_ready, frame_done} !== 6'b0_00_010) begin
      fails++;
      $display("FAIL reset_release: got %b expected %b", {f, sel, busy, in_ready, frame_done}, 6'b0_00_010);
    end
  endtask

  task automatic test_single();
    logic [5:0] exp;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hA5; in_dest = CH_C;
    for (int unsigned k = 1; k <= P + 1; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      exp = model(8'hA5, CH_C, k);
      checks++;
      if ({f, sel, busy, in_ready, frame_done} !== exp) begin
        fails++;
        $display("FAIL single k=%0d: got %b expected %b", k, {f, sel, busy, in_ready, frame_done}, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp;
    int pulses = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hFF; in_dest = CH_A;
    for (int unsigned k = 1; k <= P; k++) begin
      @(negedge clk);
      if (k == 1) begin
        in_data = 8'h01; in_dest = CH_D;
      end
      pulses += int'(frame_done);
      exp = model(8'hFF, CH_A, k);
      checks++;
      if ({f, sel, busy, in_ready, frame_done} !== exp) begin
        fails++;
        $display("FAIL b2b_first k=%0d: got %b expected %b", k, {f, sel, busy, in_ready, frame_done}, exp);
      end
    end
    for (int unsigned k = 1; k <= P + 1; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      pulses += int'(frame_done);
      exp = model(8'h01, CH_D, k);
      checks++;
      if ({f, sel, busy, in_ready, frame_done} !== exp) begin
        fails++;
        $display("FAIL b2b_second k=%0d: got %b expected %b", k, {f, sel, busy, in_ready, frame_done}, exp);
      end
    end
    checks++;
    if (pulses != 2) begin
      fails++;
      $display("FAIL b2b_done_count: got %0d expected 2", pulses);
    end
  endtask

  task automatic test_abort();
    logic [5:0]   exp;
    logic [W-1:0] d;
    logic [1:0]   ds;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h3C; in_dest = CH_B;
    for (int unsigned k = 1; k <= 5; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      exp = model(8'h3C, CH_B, k);
      checks++;
      if ({f, sel, busy, in_ready, frame_done} !== exp) begin
        fails++;
        $display("FAIL abort_pre k=%0d: got %b expected %b", k, {f, sel, busy, in_ready, frame_done}, exp);
      end
    end
    abort = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if ({f, sel, busy, in_ready, frame_done} !== {1'b0, CH_B, 3'b010}) begin
        fails++;
        $display("FAIL abort_idle k=%0d: got %b expected %b", k, {f, sel, busy, in_ready, frame_done}, {1'b0, CH_B, 3'b010});
      end
    end
    d = W'($urandom); ds = 2'($urandom);
    in_valid = 1'b1; abort = 1'b1; in_data = d; in_dest = ds;
    for (int unsigned k = 1; k <= P + 1; k++) begin
      @(negedge clk);
      in_valid = 1'b0; abort = 1'b0;
      exp = model(d, ds, k);
      checks++;
      if ({f, sel, busy, in_ready, frame_done} !== exp) begin
        fails++;
        $display("FAIL abort_then_frame k=%0d: got %b expected %b", k, {f, sel, busy, in_ready, frame_done}, exp);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [5:0]   exp;
    logic [W-1:0] d;
    logic [1:0]   ds;
    d = W'($urandom); ds = 2'($urandom);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_dest = ds;
    for (int unsigned k = 1; k <= 6; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      exp = model(d, ds, k);
      checks++;
      if ({f, sel, busy, in_ready, frame_done} !== exp) begin
        fails++;
        $display("FAIL midreset_pre k=%0d: got %b expected %b", k, {f, sel, busy, in_ready, frame_done}, exp);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({f, sel, busy, in_ready, frame_done} !== 6'b0_00_010) begin
      fails++;
      $display("FAIL midreset_async: got %b expected %b", {f, sel, busy, in_ready, frame_done}, 6'b0_00_010);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h81; in_dest = CH_D;
    for (int unsigned k = 1; k <= P + 1; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      exp = model(8'h81, CH_D, k);
      checks++;
      if ({f, sel, busy, in_ready, frame_done} !== exp) begin
        fails++;
        $display("FAIL midreset_post k=%0d: got %b expected %b", k, {f, sel, busy, in_ready, frame_done}, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0]   exp;
    logic [W-1:0] d;
    logic [1:0]   ds;
    for (int unsigned n = 0; n < 8; n++) begin
      d = W'($urandom); ds = 2'($urandom);
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_dest = ds;
      for (int unsigned k = 1; k <= P + 1; k++) begin
        @(negedge clk);
        exp = model(d, ds, k);
        checks++;
        if ({f, sel, busy, in_ready, frame_done} !== exp) begin
          fails++;
          $display("FAIL random n=%0d k=%0d: got %b expected %b", n, k, {f, sel, busy, in_ready, frame_done}, exp);
        end
        // Junk offers while busy must be ignored; quiet again before IDLE.
        in_valid = (k < P) ? 1'($urandom) : 1'b0;
        in_data  = W'($urandom);
        in_dest  = 2'($urandom);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_corner();
    @(negedge clk);
    in_valid1 = 1'b1; in_data1 = 1'b1; in_dest1 = CH_A;
    for (int unsigned ch = 0; ch < 4; ch++) begin
      @(negedge clk);
      checks++;
      if ({f1, sel1, busy1, in_ready1, fd1} !== {1'b1, 2'(ch), 3'b100}) begin
        fails++;
        $display("FAIL corner_bit ch=%0d: got %b expected %b", ch, {f1, sel1, busy1, in_ready1, fd1}, {1'b1, 2'(ch), 3'b100});
      end
      checks++;
      if (route !== (4'b0001 << ch)) begin
        fails++;
        $display("FAIL corner_route ch=%0d: got %b expected %b", ch, route, 4'b0001 << ch);
      end
      if (ch < 3) in_dest1 = 2'(ch + 1);
      else in_valid1 = 1'b0;
      @(negedge clk);
      checks++;
      if ({f1, sel1, busy1, in_ready1, fd1} !== {1'b0, 2'(ch), 3'b011}) begin
        fails++;
        $display("FAIL corner_done ch=%0d: got %b expected %b", ch, {f1, sel1, busy1, in_ready1, fd1}, {1'b0, 2'(ch), 3'b011});
      end
    end
    @(negedge clk);
    checks++;
    if ({f1, sel1, busy1, in_ready1, fd1} !== {1'b0, CH_D, 3'b010}) begin
      fails++;
      $display("FAIL corner_idle: got %b expected %b", {f1, sel1, busy1, in_ready1, fd1}, {1'b0, CH_D, 3'b010});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_reset_midframe();
    test_random();
    test_corner();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
